// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle between the pipeline and the multiply/divide unit.
//   start    - request a new operation (sampled only while the unit is idle)
//   op       - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data  - first operand (multiplicand / dividend), also MTHI/MTLO source
//   rt_data  - second operand (multiplier / divisor)
//   hi_wr    - MTHI strobe, lo_wr - MTLO strobe
//   busy     - operation in progress, done - one-cycle result pulse
//   hi, lo   - architectural HI/LO registers
interface mult_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_wr;
    logic        lo_wr;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_wr, lo_wr,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_wr, lo_wr,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-cycle multiply / restoring divide unit with HI/LO registers.
//   clk - clock, all state changes on the rising edge
//   rst - synchronous active-high reset
//   bus - mult_div_unit_if.slave (start/op/operands/MTHI/MTLO in, busy/done/hi/lo out)
// Latency: start accepted at edge k -> busy for 33 cycles, done and new hi/lo in the last one.
// Macro MULT_DIV_UNIT_DIV_EN enables DIV/DIVU; without it the divider datapath is
// not built and divide requests are ignored.
module mult_div_unit (
    input  logic            clk,
    input  logic            rst,
    mult_div_unit_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [4:0]  cnt_q, cnt_d;
    // Working register: {partial product, multiplier} or {remainder, dividend/quotient}.
    logic [63:0] w_q, w_d;
    // Multiplicand magnitude or divisor magnitude.
    logic [31:0] a_q, a_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;   // product / quotient must be negated
    logic        neg_rem_q, neg_rem_d;   // remainder takes the dividend's sign
    logic        div_zero_q, div_zero_d;

    logic        op_ok;
    logic        accept;
    logic        op_signed;
    logic        rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag;
    logic [32:0] sum;
    logic [63:0] mul_next;
    logic [63:0] step_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

`ifdef MULT_DIV_UNIT_DIV_EN
    logic [32:0] t;
    logic        ge;
    logic [31:0] rem_new;
    logic [63:0] div_next;

    // Restoring divide step: shift in the next dividend bit, subtract if it fits.
    // Both the difference and the unsubtracted value are < divisor, so 32 bits suffice.
    always_comb begin
        t        = {w_q[63:32], w_q[31]};
        ge       = (t >= {1'b0, a_q});
        rem_new  = ge ? (t[31:0] - a_q) : t[31:0];
        div_next = {rem_new, w_q[30:0], ge};
    end

    assign op_ok     = 1'b1;
    assign step_next = is_div_q ? div_next : mul_next;
`else
    assign op_ok     = ~bus.op[1];
    assign step_next = mul_next;
`endif

    // Shift-add multiply step: conditionally add multiplicand into the top half, shift right.
    always_comb begin
        sum      = {1'b0, w_q[63:32]} + (w_q[0] ? {1'b0, a_q} : 33'd0);
        mul_next = {sum, w_q[31:1]};
    end

    always_comb begin
        op_signed = ~bus.op[0];
        rs_neg    = op_signed & bus.rs_data[31];
        rt_neg    = op_signed & bus.rt_data[31];
        // 32'h8000_0000 negates to itself, which is the correct unsigned magnitude.
        rs_mag    = rs_neg ? (~bus.rs_data + 32'd1) : bus.rs_data;
        rt_mag    = rt_neg ? (~bus.rt_data + 32'd1) : bus.rt_data;
        accept    = (state_q == StIdle) && bus.start && op_ok;

        prod_fix  = neg_res_q ? (~step_next + 64'd1) : step_next;
        // Divide by zero keeps the raw all-ones quotient regardless of operand signs.
        quo_fix   = (neg_res_q && !div_zero_q) ? (~step_next[31:0] + 32'd1) : step_next[31:0];
        rem_fix   = neg_rem_q ? (~step_next[63:32] + 32'd1) : step_next[63:32];
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        w_d        = w_q;
        a_d        = a_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d    = StCalc;
                    busy_d     = 1'b1;
                    cnt_d      = 5'd0;
                    is_div_d   = bus.op[1];
                    neg_res_d  = rs_neg ^ rt_neg;
                    neg_rem_d  = rs_neg;
                    div_zero_d = (bus.rt_data == 32'd0);
                    if (bus.op[1]) begin
                        a_d = rt_mag;
                        w_d = {32'd0, rs_mag};
                    end else begin
                        a_d = rs_mag;
                        w_d = {32'd0, rt_mag};
                    end
                end else if (!bus.start) begin
                    if (bus.hi_wr) hi_d = bus.rs_data;
                    if (bus.lo_wr) lo_d = bus.rs_data;
                end
            end
            StCalc: begin
                w_d   = step_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            cnt_q      <= 5'd0;
            w_q        <= 64'd0;
            a_q        <= 32'd0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            w_q        <= w_d;
            a_q        <= a_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, hand sequences and random ops
// against an arithmetic reference model.
module tb_mult_div_unit;

`ifdef MULT_DIV_UNIT_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_hi     = 32'd0;
    logic [31:0] m_lo     = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic; divide by zero gives {rs, all-ones}.
    function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic ign,
                                  output logic [31:0] h, output logic [31:0] l);
        longint      sa, sb, q, r;
        logic [63:0] p;
        ign = op[1] && !DivEn;
        h   = m_hi;
        l   = m_lo;
        if (ign) return;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin
                p = 64'(sa * sb);
                h = p[63:32];
                l = p[31:0];
            end
            2'd1: begin
                p = 64'(a) * 64'(b);
                h = p[63:32];
                l = p[31:0];
            end
            2'd2: begin
                if (b == 32'd0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    h = r[31:0];
                    l = q[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else begin
                    h = a % b;
                    l = a / b;
                end
            end
        endcase
    endfunction

    // Issue one op and watch 36 cycles; optional interference (second start or MTHI) at cycle ip.
    task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input logic ign, input int ip, input logic i_start,
                          input logic i_hiwr);
        int   first_done = 0;
        int   ndone      = 0;
        int   busy_bad   = 0;
        int   unstable   = 0;
        logic exp_busy;
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        cyc();
        bus.start = 1'b0;
        for (int p = 1; p <= 36; p++) begin
            exp_busy = !ign && (p <= 33);
            if (bus.busy !== exp_busy) busy_bad++;
            if (bus.done !== 1'b0) begin
                ndone++;
                if (first_done == 0) first_done = p;
            end
            if ((ign || p < 33) && (bus.hi !== m_hi || bus.lo !== m_lo)) unstable++;
            if (p == ip) begin
                bus.start   = i_start;
                bus.op      = 2'b01;
                bus.rs_data = i_hiwr ? 32'hDEAD_BEEF : 32'd2;
                bus.rt_data = 32'd2;
                bus.hi_wr   = i_hiwr;
            end
            cyc();
            bus.start = 1'b0;
            bus.hi_wr = 1'b0;
        end
        check({nm, " done_cycle"}, 64'(first_done), ign ? 64'd0 : 64'd33);
        check({nm, " done_count"}, 64'(ndone), ign ? 64'd0 : 64'd1);
        check({nm, " busy_window"}, 64'(busy_bad), 64'd0);
        check({nm, " hilo_stable"}, 64'(unstable), 64'd0);
        check({nm, " hi"}, 64'(bus.hi), 64'(eh));
        check({nm, " lo"}, 64'(bus.lo), 64'(el));
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        vec_t        vt[9];
        logic        ign;
        logic [31:0] h, l;
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        int          nd;

        vt[0] = '{"multu_max",   2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vt[1] = '{"mult_neg3x5", 2'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vt[2] = '{"div_neg7by2", 2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vt[3] = '{"divu_by0",    2'd3, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
        vt[4] = '{"div_ovf",     2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vt[5] = '{"div_neg_by0", 2'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vt[6] = '{"mult_minsq",  2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vt[7] = '{"divu_big",    2'd3, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF};
        vt[8] = '{"div_7byneg2", 2'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.rs_data = 32'd0;
        bus.rt_data = 32'd0;
        bus.hi_wr   = 1'b0;
        bus.lo_wr   = 1'b0;
        repeat (3) cyc();
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);

        // First vector starts in the very first cycle after reset release.
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ign = vt[i].op[1] && !DivEn;
            run_op(vt[i].name, vt[i].op, vt[i].a, vt[i].b, ign ? m_hi : vt[i].eh,
                   ign ? m_lo : vt[i].el, ign, 0, 1'b0, 1'b0);
        end

        // Second start while busy is ignored.
        run_op("second_start", 2'd1, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0, 10, 1'b1, 1'b0);

        // Reset in the middle of a DIVU.
        bus.start   = 1'b1;
        bus.op      = 2'd3;
        bus.rs_data = 32'd1000;
        bus.rt_data = 32'd7;
        cyc();
        bus.start = 1'b0;
        repeat (14) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst busy", 64'(bus.busy), 64'd0);
        check("midrst hi", 64'(bus.hi), 64'd0);
        check("midrst lo", 64'(bus.lo), 64'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done !== 1'b0) nd++;
            cyc();
        end
        check("midrst no_done", 64'(nd), 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        // Fresh op after reset, with an MTHI attempt during CALC that must be ignored.
        run_op("multu_6x7", 2'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 10, 1'b0, 1'b1);

        // MTHI / MTLO in idle.
        bus.rs_data = 32'hDEAD_BEEF;
        bus.hi_wr   = 1'b1;
        cyc();
        bus.hi_wr = 1'b0;
        check("mthi hi", 64'(bus.hi), 64'hDEAD_BEEF);
        check("mthi lo", 64'(bus.lo), 64'd42);
        bus.rs_data = 32'h1234_5678;
        bus.lo_wr   = 1'b1;
        cyc();
        bus.lo_wr = 1'b0;
        check("mtlo lo", 64'(bus.lo), 64'h1234_5678);
        check("mtlo hi", 64'(bus.hi), 64'hDEAD_BEEF);
        bus.rs_data = 32'hCAFE_F00D;
        bus.hi_wr   = 1'b1;
        bus.lo_wr   = 1'b1;
        cyc();
        bus.hi_wr = 1'b0;
        bus.lo_wr = 1'b0;
        check("mthilo hi", 64'(bus.hi), 64'hCAFE_F00D);
        check("mthilo lo", 64'(bus.lo), 64'hCAFE_F00D);
        m_hi = 32'hCAFE_F00D;
        m_lo = 32'hCAFE_F00D;

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            if (i % 8 == 0)                     rb = 32'd0;
            else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 20));
            else                                rb = $urandom;
            if ($urandom_range(0, 3) == 0)      ra = 32'($urandom_range(0, 300));
            model(rop, ra, rb, ign, h, l);
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, h, l, ign, 0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1: request a new operation; sampled only in IDLE.
REQ-004 SHALL have port op, input, 2: operation select, 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port rs_data, input, 32: first operand (multiplicand or dividend), fed from register-file read data 1.
REQ-006 SHALL have port rt_data, input, 32: second operand (multiplier or divisor), fed from register-file read data 2.
REQ-007 SHALL have port hi_wr, input, 1: MTHI write strobe, loads hi from rs_data.
REQ-008 SHALL have port lo_wr, input, 1: MTLO write strobe, loads lo from rs_data.
REQ-009 SHALL have port busy, output, 1: an operation is in progress.
REQ-010 SHALL have port done, output, 1: one-cycle pulse marking a new result in hi/lo.
REQ-011 SHALL have port hi, output, 32: HI register, read by MFHI toward the register-file write data.
REQ-012 SHALL have port lo, output, 32: LO register, read by MFLO toward the register-file write data.

Function
REQ-013 SHALL implement FSM states IDLE, CALC and DONE, with IDLE->CALC on an accepted start, CALC->DONE after 32 iterations, and DONE->IDLE unconditionally.
REQ-014 SHALL accept start only in IDLE, capture op, rs_data and rt_data at that edge, and ignore start while busy=1.
REQ-015 SHALL produce this timing for a start accepted at edge k: busy=1 in cycles k+1 through k+33; done=1 in cycle k+33 only; hi and lo carry the result from cycle k+33 and hold it until the next write.
REQ-016 SHALL implement the multiply as a 32-iteration shift-add producing the 64-bit product, with hi = product[63:32] and lo = product[31:0].
REQ-017 SHALL perform MULT and DIV on operand magnitudes and apply sign correction in the final iteration; MULTU and DIVU SHALL use unsigned operands.
REQ-018 SHALL implement the divide as a 32-iteration restoring divide, with lo = quotient truncated toward zero and hi = remainder carrying the sign of the dividend.
REQ-019 SHALL handle divide by zero (rt_data=0) with the full latency and produce lo=32'hFFFF_FFFF and hi=rs_data, for both signed and unsigned divides.
REQ-020 SHALL handle DIV of 32'h8000_0000 by 32'hFFFF_FFFF with lo=32'h8000_0000 and hi=0.
REQ-021 SHALL honour hi_wr and lo_wr only in IDLE with start=0, ignoring them when busy or when start is accepted in the same cycle; both may be asserted together.
REQ-022 SHALL keep hi and lo stable during CALC; intermediate values SHALL never be visible on them.

Reset
REQ-023 SHALL, while rst=1 at a rising edge, force the FSM to IDLE, set busy=0, done=0, hi=0 and lo=0, and clear all iteration state.
REQ-024 SHALL abort any operation interrupted by reset mid-CALC, producing no done pulse and no hi/lo update.
REQ-025 SHALL accept start in the first cycle after rst deasserts.

Configuration
REQ-026 SHALL, with macro MULT_DIV_UNIT_DIV_EN defined, support all four ops as specified.
REQ-027 SHALL, without MULT_DIV_UNIT_DIV_EN, omit the divider hardware; start with op=DIV or DIVU SHALL then be ignored, leaving busy=0, done=0 and hi/lo unchanged, while MULT and MULTU are unaffected.

Verification
REQ-028 SHALL cover: MULTU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001, done exactly 33 cycles after the start edge.
REQ-029 SHALL cover: MULT -3 x 5 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1; then DIV -7 / 2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
REQ-030 SHALL cover: DIVU 100 / 0 -> hi=32'h0000_0064, lo=32'hFFFF_FFFF; and DIV 32'h8000_0000 / 32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0.
REQ-031 SHALL cover: a second start (MULTU 2 x 2) at cycle k+10 of a MULTU 3 x 3 -> ignored; result hi=0, lo=9, and a single done pulse.
REQ-032 SHALL cover: rst pulsed at cycle k+15 of a DIVU -> busy=0 the next cycle, hi=lo=0, no done; then a fresh MULTU 6 x 7 -> lo=42.
REQ-033 SHALL cover: hi_wr with rs_data=32'hDEAD_BEEF in IDLE -> hi=32'hDEAD_BEEF the next cycle; the same hi_wr during CALC -> hi unchanged.
